// File: rtl/ip_daec_8lc_cell_writer.sv
// ip_daec_8lc_cell_writer
// Maps one encoded IP-DAEC word (IP flag, 22-bit IP word, 49-bit codeword)
// onto 25 eight-level cells and streams them to the array write port,
// CELLS_PER_BEAT cells per beat. A one-word pending buffer lets the next
// word be taken while the active word drains, so words stream back-to-back.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational from out_ready)
//   in_ip, in_ip_word,
//   in_codeword, in_addr  encoded word and its destination address
//   out_valid/out_ready output beat handshake
//   out_cells           beat cells, lowest-index cell in [2:0]
//   out_addr            address of the word being sent
//   out_beat, out_last  beat index within the word, final-beat flag
//   busy                active or pending word held
//   words_written       saturating count of fully sent words
module ip_daec_8lc_cell_writer #(
    parameter int CELLS_PER_BEAT = 5,
    parameter int ADDR_W         = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_ip,
    input  logic [21:0]                 in_ip_word,
    input  logic [48:0]                 in_codeword,
    input  logic [ADDR_W-1:0]           in_addr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [3*CELLS_PER_BEAT-1:0] out_cells,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [4:0]                  out_beat,
    output logic                        out_last,
    output logic                        busy,
    output logic [15:0]                 words_written
);

    localparam int         BEATS     = 25 / CELLS_PER_BEAT;
    localparam int         OUT_W     = 3 * CELLS_PER_BEAT;
    localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Cell k occupies bits [3k+2:3k] of the returned vector.
    function automatic logic [74:0] map_cells(
        input logic        ip,
        input logic [21:0] ip_word,
        input logic [48:0] codeword
    );
        logic [74:0] cells;
        cells = 75'd0;
        for (int k = 0; k < 22; k++) begin
            cells[3*k +: 3] = {ip_word[k], codeword[2*k+8], codeword[2*k+7]};
        end
        cells[68:66] = codeword[6:4];
        cells[71:69] = codeword[3:1];
        cells[74:72] = {1'b0, ip, codeword[0]};
        return cells;
    endfunction

    state_t              state_r;
    logic                pend_valid_r;
    logic [74:0]         pend_cells_r;
    logic [ADDR_W-1:0]   pend_addr_r;
    logic [74:0]         act_cells_r;
    logic [ADDR_W-1:0]   act_addr_r;
    logic [4:0]          beat_r;
    logic                last_r;
    logic [15:0]         words_written_r;

    logic                last_hs_s;
    logic                load_s;
    logic                accept_s;
    logic [4:0]          beat_next_s;

    // Handshake decode: final-beat handshake, pending-to-active load, input accept.
    always_comb begin
        last_hs_s   = 1'b0;
        load_s      = 1'b0;
        beat_next_s = beat_r + 5'd1;
        if (state_r == ST_SEND) begin
            last_hs_s = out_ready & last_r;
        end else begin
            last_hs_s = 1'b0;
        end
        load_s   = pend_valid_r & ((state_r == ST_IDLE) | last_hs_s);
        in_ready = rst_n & (~pend_valid_r | load_s);
        accept_s = in_valid & in_ready;
    end

    // Pending buffer, active word shifter, beat FSM and word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            pend_valid_r    <= 1'b0;
            pend_cells_r    <= 75'd0;
            pend_addr_r     <= {ADDR_W{1'b0}};
            act_cells_r     <= 75'd0;
            act_addr_r      <= {ADDR_W{1'b0}};
            beat_r          <= 5'd0;
            last_r          <= 1'b0;
            words_written_r <= 16'd0;
        end else begin
            // A load frees the pending slot; an accept in the same cycle refills it.
            if (accept_s) begin
                pend_valid_r <= 1'b1;
                pend_cells_r <= map_cells(in_ip, in_ip_word, in_codeword);
                pend_addr_r  <= in_addr;
            end else if (load_s) begin
                pend_valid_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r     <= ST_SEND;
                        act_cells_r <= pend_cells_r;
                        act_addr_r  <= pend_addr_r;
                        beat_r      <= 5'd0;
                        last_r      <= (LAST_BEAT == 5'd0);
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (last_r) begin
                            if (load_s) begin
                                act_cells_r <= pend_cells_r;
                                act_addr_r  <= pend_addr_r;
                                beat_r      <= 5'd0;
                                last_r      <= (LAST_BEAT == 5'd0);
                            end else begin
                                state_r <= ST_IDLE;
                                last_r  <= 1'b0;
                            end
                        end else begin
                            // Shift the next beat's cells down into the output slice.
                            act_cells_r <= act_cells_r >> OUT_W;
                            beat_r      <= beat_next_s;
                            last_r      <= (beat_next_s == LAST_BEAT);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            if (last_hs_s && (words_written_r != 16'hFFFF)) begin
                words_written_r <= words_written_r + 16'd1;
            end
        end
    end

    assign out_valid     = (state_r == ST_SEND);
    assign out_cells     = act_cells_r[OUT_W-1:0];
    assign out_addr      = act_addr_r;
    assign out_beat      = beat_r;
    assign out_last      = last_r;
    assign busy          = pend_valid_r | (state_r == ST_SEND);
    assign words_written = words_written_r;

endmodule

// File: tb/tb_ip_daec_8lc_cell_writer.sv
// Self-checking bench for ip_daec_8lc_cell_writer: a CPB=5 instance carries the
// main scenarios; CPB=1 and CPB=25 instances replay the first word for
// comparison of the concatenated cell stream.
module tb_ip_daec_8lc_cell_writer;

    typedef struct packed {
        logic [15:0] addr;
        logic [4:0]  beat;
        logic        last;
        logic [74:0] cells;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ip, out_ready;
    logic [21:0] in_ip_word;
    logic [48:0] in_codeword;
    logic [15:0] in_addr;
    logic        in_ready, out_valid, out_last, busy;
    logic [14:0] out_cells;
    logic [15:0] out_addr, words_written;
    logic [4:0]  out_beat;

    logic        in_valid_x, out_ready_x;
    logic        in_ready1, out_valid1, out_last1, busy1;
    logic [2:0]  out_cells1;
    logic [15:0] out_addr1, ww1;
    logic [4:0]  out_beat1;
    logic        in_ready25, out_valid25, out_last25, busy25;
    logic [74:0] out_cells25;
    logic [15:0] out_addr25, ww25;
    logic [4:0]  out_beat25;

    ip_daec_8lc_cell_writer #(.CELLS_PER_BEAT(5), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ip(in_ip), .in_ip_word(in_ip_word), .in_codeword(in_codeword), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_cells(out_cells), .out_addr(out_addr),
        .out_beat(out_beat), .out_last(out_last), .busy(busy), .words_written(words_written));

    ip_daec_8lc_cell_writer #(.CELLS_PER_BEAT(1), .ADDR_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready1),
        .in_ip(in_ip), .in_ip_word(in_ip_word), .in_codeword(in_codeword), .in_addr(in_addr),
        .out_valid(out_valid1), .out_ready(out_ready_x), .out_cells(out_cells1), .out_addr(out_addr1),
        .out_beat(out_beat1), .out_last(out_last1), .busy(busy1), .words_written(ww1));

    ip_daec_8lc_cell_writer #(.CELLS_PER_BEAT(25), .ADDR_W(16)) dut25 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready25),
        .in_ip(in_ip), .in_ip_word(in_ip_word), .in_codeword(in_codeword), .in_addr(in_addr),
        .out_valid(out_valid25), .out_ready(out_ready_x), .out_cells(out_cells25), .out_addr(out_addr25),
        .out_beat(out_beat25), .out_last(out_last25), .busy(busy25), .words_written(ww25));

    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    hold_err = 0;
    beat_t cap_q[$];
    beat_t exp_q[$];
    int    stamp_q[$];
    logic  held = 1'b0;
    beat_t held_v;
    logic [74:0] acc1 = 75'd0;
    logic [74:0] acc25 = 75'd0;
    int    cnt1 = 0, cnt25 = 0, last1 = 0, bad25 = 0;
    logic [15:0] addr1_seen = 16'd0, addr25_seen = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record main-instance handshakes and check outputs hold during stalls.
    always @(negedge clk) begin
        beat_t cur;
        cur.addr  = out_addr;
        cur.beat  = out_beat;
        cur.last  = out_last;
        cur.cells = 75'(out_cells);
        if (rst_n) begin
            if (held && (cur !== held_v)) hold_err++;
            if (out_valid && out_ready) begin
                cap_q.push_back(cur);
                stamp_q.push_back(cyc);
            end
            held   = out_valid && !out_ready;
            held_v = cur;
        end else begin
            held = 1'b0;
        end
    end

    // Collect the CPB=1 and CPB=25 streams (their out_ready is always high).
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid1) begin
                acc1[3*out_beat1 +: 3] = out_cells1;
                cnt1++;
                if (out_last1) last1++;
                addr1_seen = out_addr1;
            end
            if (out_valid25) begin
                acc25 = out_cells25;
                cnt25++;
                if (!out_last25 || out_beat25 != 5'd0) bad25++;
                addr25_seen = out_addr25;
            end
        end
    end

    // Reference cell map, level = 4*msb + 2*mid + lsb from the cell rules.
    function automatic logic [74:0] model(input logic ip, input logic [21:0] w, input logic [48:0] cw);
        logic [74:0] r;
        int lvl;
        r = 75'd0;
        for (int k = 0; k < 25; k++) begin
            if (k < 22)       lvl = 4 * int'(w[k]) + 2 * int'(cw[2*k+8]) + int'(cw[2*k+7]);
            else if (k == 22) lvl = int'(cw[6:4]);
            else if (k == 23) lvl = int'(cw[3:1]);
            else              lvl = 2 * int'(ip) + int'(cw[0]);
            r = r | (75'(lvl) << (3 * k));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, wait (bounded) for acceptance, queue its expected beats.
    task automatic push(input logic ip, input logic [21:0] w, input logic [48:0] cw, input logic [15:0] a);
        logic [74:0] m;
        beat_t e;
        int c;
        in_valid = 1'b1; in_ip = ip; in_ip_word = w; in_codeword = cw; in_addr = a;
        c = 0;
        @(negedge clk);
        while (!in_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("push_accept", in_ready, 1'b1);
        acc_cyc = cyc;
        step();
        in_valid = 1'b0;
        m = model(ip, w, cw);
        for (int b = 0; b < 5; b++) begin
            e.addr = a; e.beat = 5'(b); e.last = (b == 4);
            e.cells = (m >> (15 * b)) & 75'h7FFF;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_rand();
        push(1'($urandom), 22'($urandom), {17'($urandom), 32'($urandom)}, 16'($urandom));
    endtask

    task automatic drain();
        int c;
        c = 0;
        @(negedge clk);
        while (busy && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("drain_idle", busy, 1'b0);
    endtask

    task automatic wait_beat(input logic [4:0] b);
        int c;
        c = 0;
        @(negedge clk);
        while (!(out_valid && out_beat == b) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("reach_beat", out_beat, b);
    endtask

    task automatic compare_sb(input string tag);
        int n;
        check($sformatf("%s_count", tag), cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cells%0d", tag, i), cap_q[i].cells, exp_q[i].cells);
            check($sformatf("%s_addr%0d", tag, i), cap_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_beat%0d", tag, i), cap_q[i].beat, exp_q[i].beat);
            check($sformatf("%s_last%0d", tag, i), cap_q[i].last, exp_q[i].last);
        end
        cap_q.delete(); exp_q.delete(); stamp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        logic [21:0] cw_w;
        logic [48:0] cw_c;
        logic [15:0] cw_a;
        logic [74:0] m1;
        rst_n = 1'b0; in_valid = 1'b0; in_ip = 1'b0; in_ip_word = 22'd0; in_codeword = 49'd0;
        in_addr = 16'd0; out_ready = 1'b1; in_valid_x = 1'b0; out_ready_x = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ww", words_written, 16'd0);
        check("rst_cells", out_cells, 15'd0);
        check("rst_addr", out_addr, 16'd0);
        check("rst_beat", out_beat, 5'd0);
        check("rst_last", out_last, 1'b0);
        step();
        rst_n = 1'b1;

        // Directed: all-ones IP word, zero codeword.
        push(1'b1, 22'h3FFFFF, 49'd0, 16'h0010);
        drain();
        if (stamp_q.size() > 0) check("latency", stamp_q[0], acc_cyc + 2);
        if (cap_q.size() == 5) begin
            check("d1_b0_const", cap_q[0].cells, 75'h4924);
            check("d1_b4_const", cap_q[4].cells, 75'h2024);
            check("d1_b4_last", cap_q[4].last, 1'b1);
        end
        check("d1_ww", words_written, 16'd1);
        compare_sb("d1");
        step();

        // Directed: single codeword bits.
        push(1'b0, 22'd0, 49'h1, 16'h0020);
        drain();
        if (cap_q.size() == 5) check("d2_b4_const", cap_q[4].cells, 75'h1000);
        compare_sb("d2");
        step();
        push(1'b0, 22'd0, 49'h80, 16'h0021);
        drain();
        if (cap_q.size() == 5) check("d3_b0_const", cap_q[0].cells, 75'h0001);
        compare_sb("d3");
        check("d3_ww", words_written, 16'd3);
        step();

        // Three random words back-to-back.
        push_rand(); push_rand(); push_rand();
        drain();
        gaps = 0;
        for (int i = 1; i < stamp_q.size(); i++) if (stamp_q[i] != stamp_q[i-1] + 1) gaps++;
        check("b2b_gaps", gaps, 0);
        compare_sb("b2b");
        check("b2b_ww", words_written, 16'd6);
        step();

        // Stall during the first word with a second word pending.
        push_rand(); push_rand();
        wait_beat(5'd1);
        step();
        out_ready = 1'b0;
        cw_w = 22'($urandom); cw_c = {17'($urandom), 32'($urandom)}; cw_a = 16'($urandom);
        in_valid = 1'b1; in_ip = 1'b1; in_ip_word = cw_w; in_codeword = cw_c; in_addr = cw_a;
        @(negedge clk);
        check("stall_in_ready_a", in_ready, 1'b0);
        step();
        @(negedge clk);
        check("stall_in_ready_b", in_ready, 1'b0);
        step();
        out_ready = 1'b1;
        in_valid = 1'b0;
        push(1'b1, cw_w, cw_c, cw_a);
        drain();
        check("stall_hold", hold_err, 0);
        compare_sb("stall");
        check("stall_ww", words_written, 16'd9);
        step();

        // Reset mid-word with a second word pending.
        push_rand(); push_rand();
        wait_beat(5'd2);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_ww", words_written, 16'd0);
        check("mrst_in_ready", in_ready, 1'b1);
        cap_q.delete(); exp_q.delete(); stamp_q.delete();
        step();
        push_rand();
        drain();
        if (cap_q.size() > 0) check("mrst_first_beat", cap_q[0].beat, 5'd0);
        compare_sb("mrst");
        check("mrst_ww_after", words_written, 16'd1);
        step();

        // CPB=1 and CPB=25 replay of the first directed word.
        in_ip = 1'b1; in_ip_word = 22'h3FFFFF; in_codeword = 49'd0; in_addr = 16'h0010;
        in_valid_x = 1'b1;
        @(negedge clk);
        check("x1_in_ready", in_ready1, 1'b1);
        check("x25_in_ready", in_ready25, 1'b1);
        step();
        in_valid_x = 1'b0;
        for (int c = 0; c < 60 && (busy1 || busy25); c++) @(negedge clk);
        @(negedge clk);
        m1 = model(1'b1, 22'h3FFFFF, 49'd0);
        check("x1_idle", busy1, 1'b0);
        check("x1_count", cnt1, 25);
        check("x1_lasts", last1, 1);
        check("x1_cells", acc1, m1);
        check("x1_addr", addr1_seen, 16'h0010);
        check("x1_ww", ww1, 16'd1);
        check("x25_idle", busy25, 1'b0);
        check("x25_count", cnt25, 1);
        check("x25_last_beat", bad25, 0);
        check("x25_cells", acc25, m1);
        check("x25_addr", addr25_seen, 16'h0010);
        check("x25_ww", ww25, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ip_daec_8lc_cell_writer.md
# ip_daec_8lc_cell_writer

Downstream stage of the IP-DAEC 8LC encoder. It accepts one encoded word per valid/ready handshake: the IP flag, the 22-bit IP word and the 49-bit codeword. It maps the 72 stored bits onto 25 eight-level (3-bit) cells and streams them to the array write port, CELLS_PER_BEAT cells per beat. A one-word pending buffer lets the next word be accepted while the current one drains, so consecutive words stream back-to-back.

## Interface
- CELLS_PER_BEAT, 5, cells per output beat; legal values 1, 5, 25; BEATS = 25/CELLS_PER_BEAT
- ADDR_W, 16, array word-address width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  encoded word present
- in_ready  out  1  word accepted when in_valid & in_ready
- in_ip  in  1  IP flag from encoder
- in_ip_word  in  22  IP word from encoder
- in_codeword  in  49  codeword from encoder
- in_addr  in  ADDR_W  destination word address
- out_valid  out  1  beat present
- out_ready  in  1  array accepts beat
- out_cells  out  3*CELLS_PER_BEAT  cell levels; lowest-index cell in [2:0]
- out_addr  out  ADDR_W  address of the word being sent
- out_beat  out  5  beat index within word, 0..BEATS-1
- out_last  out  1  high on beat BEATS-1
- busy  out  1  active or pending word held
- words_written  out  16  saturating count of fully sent words

## Operation
- Cell map per word, cells 0..24:
  - cell k (k = 0..21) = {ip_word[k], codeword[2k+8], codeword[2k+7]}
  - cell 22 = codeword[6:4]
  - cell 23 = codeword[3:1]
  - cell 24 = {1'b0, ip, codeword[0]}
- Beat b carries cells b*CPB .. b*CPB+CPB-1. Cell b*CPB sits in out_cells[2:0].
- Storage has two registers: pending (pend_valid, word, addr) and active (word, addr, beat counter).
- FSM states:
  - IDLE: out_valid=0.
  - SEND: out_valid=1.
- load = pend_valid & (IDLE | (SEND & out_ready & out_last)).
- On load: active ← pending, beat ← 0, state ← SEND, pend_valid cleared unless refilled in the same cycle.
- SEND, out_ready & !out_last: beat increments.
- SEND, out_ready & out_last, no load: state ← IDLE.
- in_ready = rst_n & (!pend_valid | load). This path is combinational from out_ready, by design.
- Input handshake: pending ← input and pend_valid ← 1. Load and refill in the same cycle are legal; the old pending word moves to active and the new word enters pending.
- words_written increments on every out_ready & out_last handshake and saturates at 16'hFFFF.
- busy = pend_valid | (state == SEND).

## Timing
- Reset (rst_n low at a clock edge):
  - state IDLE, pend_valid 0, beat 0, words_written 0
  - out_valid, out_last, busy, out_cells, out_addr, out_beat all 0
  - in_ready is 0 while rst_n is low
- Reset mid-word: active and pending words are dropped with no further beats. Nothing is counted.
- Latency: input accepted at edge t → pending at t+1 → beat 0 valid after edge t+2 if the block was IDLE.
- While out_valid=1 and out_ready=0, out_cells, out_addr, out_beat and out_last hold stable.
- Throughput with out_ready tied high: one word per BEATS cycles, and no idle cycle between words while pending is refilled.
- CELLS_PER_BEAT=25: out_last is always 1 and out_beat is always 0.
- Pending full and active stalled: in_ready=0 until the last beat of the active word handshakes.

## Test plan
- CPB=5; ip=1, ip_word=22'h3FFFFF, codeword=0, addr=16'h0010; out_ready=1 → 5 beats, beat0 out_cells=15'h4924, beat4 out_cells=15'h2024 with out_last=1, out_addr=16'h0010 on all beats, words_written=1.
- CPB=5; ip=0, ip_word=0, codeword=49'h1 → cell24=3'b001, so beat4 out_cells=15'h1000 and all other beats are 0. With codeword=49'h80 (bit 7), beat0 out_cells=15'h0001.
- Three words pushed back-to-back with out_ready=1 → 15 consecutive beats with no gap. in_ready drops only while pending is full and not loading. Beat order and addresses are preserved and words_written=3.
- out_ready toggled 1,0,0,1 during word 1 → outputs hold through the stalls and no beat is duplicated or skipped. A second word offered during the stall waits with in_ready=0 after pending fills.
- rst_n pulled low for one cycle at beat 2 of a word with a second word pending → the next cycle has out_valid=0, busy=0, words_written=0, in_ready=1. A fresh word then starts at beat 0.
- CPB=1 and CPB=25 runs of the first scenario → 25 beats versus 1 beat. The concatenated cells are identical in both configurations and to the CPB=5 run.
